fetch_stall_ctrl: RTL
=====================

Name: fetch_stall_ctrl

Overview:
Sequencer for the fetch stage: resolves decode stall, branch-wait, frame-stall and memory-stage redirect requests into one priority-ordered fetch command per cycle.
Outputs tell fetch whether to advance PC, hold the FE/DE latch, inject a bubble, or load a branch target.
Sits between decode/memory hazard signals and the fetch PC/IR registers; it is the only block allowed to steer fetch PC.

Parameters:
PC_WIDTH, 16, width of PC and branch target
BR_TIMEOUT, 7, max cycles in BRWAIT before forced release (1..2^CNT_W-1)
CNT_W, 3, width of branch-wait counter

Ports:
I_CLOCK  in  1  single clock; all state updates on posedge
I_RESET  in  1  synchronous, active-high reset
I_LOCK  in  1  pipeline enable from top level; 0 = hold in IDLE
I_BranchStallSignal  in  1  decode: branch in flight, target unresolved
I_DepStallSignal  in  1  decode: register dependency detected
I_FRAMESTALL  in  1  frame-level stall from top level
I_BranchAddrSelect  in  1  memory stage: branch target valid this cycle
I_BranchPC  in  PC_WIDTH  resolved branch target
O_FetchEn  out  1  fetch advances PC and loads IR this cycle
O_FetchStall  out  1  FE/DE latch content is a bubble (NOP downstream)
O_PCSel  out  1  1 = next PC taken from O_TargetPC
O_TargetPC  out  PC_WIDTH  captured branch target
O_State  out  3  current state encoding
O_BrTimeout  out  1  sticky: branch wait exceeded BR_TIMEOUT
O_StallCycles  out  16  perf counter (see Optional Feature)

Behaviour:
- Moore FSM; all outputs decode from registered state, valid 1 cycle after the causing input edge.
- States / outputs (FetchEn, FetchStall, PCSel):
- IDLE=0: 0,1,0.
- RUN=1: 1,0,0.
- DEP=2: 0,0,0 (hold latch, no bubble).
- BRWAIT=3: 0,1,0.
- REDIR=4: 1,0,1.
- FRAME=5: 0,0,0.
- Next-state priority from RUN/DEP/FRAME/REDIR/IDLE, highest first:
- I_RESET -> IDLE.
- !I_LOCK -> IDLE.
- I_BranchAddrSelect -> REDIR; capture O_TargetPC <= I_BranchPC.
- I_FRAMESTALL -> FRAME.
- I_BranchStallSignal && !I_DepStallSignal -> BRWAIT.
- I_DepStallSignal -> DEP.
- Otherwise -> RUN.
- BRWAIT exits only as follows:
- I_BranchAddrSelect -> REDIR, with target capture.
- wait counter == BR_TIMEOUT -> RUN and set O_BrTimeout.
- I_RESET or !I_LOCK -> IDLE.
- I_FRAMESTALL does NOT preempt BRWAIT.
- Wait counter: cleared on BRWAIT entry; +1 each cycle in BRWAIT; does not wrap; cleared on exit.
- REDIR lasts exactly one cycle, then normal priority is re-evaluated.
- Back-to-back I_BranchAddrSelect keeps REDIR and recaptures the target each cycle.
- Branch and dependency stall both high: treated as dependency (DEP); BRWAIT is entered once dependency drops while branch stall remains.
- Reset values:
- state IDLE; O_TargetPC 0; counter 0; O_BrTimeout 0; O_StallCycles 0.
- Resulting outputs: FetchEn 0, FetchStall 1, PCSel 0.
- O_BrTimeout is cleared only by I_RESET.
- Reset mid-BRWAIT or mid-REDIR discards the pending target (O_TargetPC <= 0).

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: O_StallCycles counts cycles with state in {DEP, BRWAIT, FRAME}; 16-bit, saturates at 16'hFFFF, cleared by I_RESET.
- Undefined: O_StallCycles tied to 0; counter logic absent.

Test Plan:
1. Reset, then I_LOCK=1 with no stalls -> IDLE then RUN; FetchEn=1, FetchStall=0 from the 2nd cycle onward.
2. DepStall high 3 cycles in RUN -> 3 cycles DEP (FetchEn=0, FetchStall=0), then RUN.
3. BranchStall high, then BranchAddrSelect with BranchPC=16'h0040 after 4 cycles -> 4 BRWAIT cycles (FetchStall=1), 1 REDIR cycle (PCSel=1, TargetPC=16'h0040), then RUN.
4. BranchStall held, no resolve, BR_TIMEOUT=7 -> 7 BRWAIT cycles, then RUN with O_BrTimeout=1; it stays 1 after a later normal branch.
5. Simultaneous FRAMESTALL and BranchAddrSelect in RUN -> REDIR first, then FRAME; I_RESET asserted during BRWAIT -> IDLE next cycle, TargetPC=0.
6. With FETCH_PERF_CNT_EN: 2 DEP + 4 BRWAIT + 3 FRAME cycles -> O_StallCycles=9; without the macro -> 0.

Source files
------------

// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: priority sequencer turning hazard/redirect requests into one fetch command per cycle.
// Optional stall-cycle perf counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_stall_ctrl #(
    parameter int PC_WIDTH   = 16,
    parameter int BR_TIMEOUT = 7,
    parameter int CNT_W      = 3
) (
    input  logic                I_CLOCK,
    input  logic                I_RESET,
    input  logic                I_LOCK,
    input  logic                I_BranchStallSignal,
    input  logic                I_DepStallSignal,
    input  logic                I_FRAMESTALL,
    input  logic                I_BranchAddrSelect,
    input  logic [PC_WIDTH-1:0] I_BranchPC,
    output logic                O_FetchEn,
    output logic                O_FetchStall,
    output logic                O_PCSel,
    output logic [PC_WIDTH-1:0] O_TargetPC,
    output logic [2:0]          O_State,
    output logic                O_BrTimeout,
    output logic [15:0]         O_StallCycles
);
    typedef enum logic [2:0] {IDLE, RUN, DEP, BRWAIT, REDIR, FRAME} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt;
    logic                 timeout_hit;

    // cnt holds completed BRWAIT cycles, so the last allowed cycle sees BR_TIMEOUT-1
    always_comb begin
        timeout_hit = (state == BRWAIT) && (cnt == CNT_W'(BR_TIMEOUT - 1));
        state_nx    = RUN;
        if (!I_LOCK)
            state_nx = IDLE;
        else if (I_BranchAddrSelect)
            state_nx = REDIR;
        else if (state == BRWAIT)
            state_nx = timeout_hit ? RUN : BRWAIT;
        else if (I_FRAMESTALL)
            state_nx = FRAME;
        else if (I_BranchStallSignal && !I_DepStallSignal)
            state_nx = BRWAIT;
        else if (I_DepStallSignal)
            state_nx = DEP;
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            O_TargetPC  <= '0;
            O_BrTimeout <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state == BRWAIT && state_nx == BRWAIT) ? cnt + 1'b1 : '0;
            if (state_nx == REDIR)
                O_TargetPC <= I_BranchPC;
            if (timeout_hit && state_nx == RUN)
                O_BrTimeout <= 1'b1;
        end
    end

    assign O_FetchEn    = (state == RUN) || (state == REDIR);
    assign O_FetchStall = (state == IDLE) || (state == BRWAIT);
    assign O_PCSel      = (state == REDIR);
    assign O_State      = state;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET)
            stall_cnt <= '0;
        else if ((state == DEP || state == BRWAIT || state == FRAME) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign O_StallCycles = stall_cnt;
`else
    assign O_StallCycles = 16'd0;
`endif
endmodule
